// File: rtl/kypd_scan_ctrl_if.sv
// Keypad scanner bus: matrix drive/sense, key event handshake and overflow status.
// The master drives the rows and consumes events; the slave is the scan controller.
interface kypd_scan_ctrl_if;
  logic [3:0] ROW;
  logic [3:0] COL;
  logic       KEY_READY;
  logic       KEY_VALID;
  logic [3:0] KEY_CODE;
  logic       KEY_HELD;
  logic       CLR_OVF;
  logic       OVERFLOW;

  modport master (
    output ROW, KEY_READY, CLR_OVF,
    input  COL, KEY_VALID, KEY_CODE, KEY_HELD, OVERFLOW
  );

  modport slave (
    input  ROW, KEY_READY, CLR_OVF,
    output COL, KEY_VALID, KEY_CODE, KEY_HELD, OVERFLOW
  );
endinterface

// File: rtl/kypd_scan_ctrl.sv
// 4x4 keypad scanner: one-cold column sweep, sweep-level debounce, press events
// into a 4-entry FIFO with sticky overflow.
//
// state    | meaning
// ST_DRIVE | column COL driven, settle counter sc runs 0..SETTLE_CYC-1, rows sampled on last count
// ST_EVAL  | one cycle after column 3: compare snapshot with candidate, update debounce/stable
module kypd_scan_ctrl #(
  parameter int SETTLE_CYC   = 4,
  parameter int DEBOUNCE_CNT = 8
) (
  input logic            CLK,
  input logic            ARSTL,
  kypd_scan_ctrl_if.slave kp
);

  typedef enum logic {ST_DRIVE = 1'b0, ST_EVAL = 1'b1} state_t;

  localparam logic [3:0] SC_LAST = 4'(SETTLE_CYC - 1);
  localparam logic [3:0] DC_LAST = 4'(DEBOUNCE_CNT - 1);
  localparam logic [3:0] DC_PRE  = 4'(DEBOUNCE_CNT - 2);
  localparam logic [3:0] COL0    = 4'b1110;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_sc, w_sc_nxt;
  logic [1:0]  r_c, w_c_nxt;
  logic [3:0]  r_col, w_col_nxt;
  logic        w_capture;
  logic        w_eval;
  logic        w_col_ok;

  logic [15:0] r_snap, r_cand, r_stable;
  logic [3:0]  r_dc;
  logic        w_same;
  logic        w_load_stable;
  logic        w_push;
  logic [3:0]  w_code;
  logic [3:0]  w_idx;

  logic [3:0]  r_mem [4];
  logic [1:0]  r_wr_ptr, r_rd_ptr, w_rd_nxt;
  logic [2:0]  r_count, w_count_nxt;
  logic        r_key_valid;
  logic [3:0]  r_key_code, w_head_nxt;
  logic        r_ovf;
  logic        w_pop, w_full, w_wr, w_drop;

  assign w_col_ok = $onehot(~r_col);

  always_ff @(posedge CLK or negedge ARSTL) begin
    if (!ARSTL) begin
      r_state <= ST_DRIVE;
      r_sc    <= '0;
      r_c     <= '0;
      r_col   <= COL0;
    end else begin
      r_state <= w_state_nxt;
      r_sc    <= w_sc_nxt;
      r_c     <= w_c_nxt;
      r_col   <= w_col_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sc_nxt    = r_sc;
    w_c_nxt     = r_c;
    w_col_nxt   = r_col;
    w_capture   = 1'b0;
    w_eval      = 1'b0;
    // A corrupted strobe restarts the sweep rather than driving two columns.
    if (!w_col_ok) begin
      w_state_nxt = ST_DRIVE;
      w_sc_nxt    = '0;
      w_c_nxt     = '0;
      w_col_nxt   = COL0;
    end else begin
      case (r_state)
        ST_DRIVE: begin
          if (r_sc == SC_LAST) begin
            w_capture = 1'b1;
            w_sc_nxt  = '0;
            if (r_c == 2'd3) begin
              w_state_nxt = ST_EVAL;
              w_c_nxt     = '0;
              w_col_nxt   = COL0;
            end else begin
              w_c_nxt   = r_c + 2'd1;
              w_col_nxt = {r_col[2:0], 1'b1};
            end
          end else begin
            w_sc_nxt = r_sc + 4'd1;
          end
        end
        ST_EVAL: begin
          w_eval      = 1'b1;
          w_state_nxt = ST_DRIVE;
        end
        default: w_state_nxt = ST_DRIVE;
      endcase
    end
  end

  assign w_same        = (r_snap == r_cand);
  assign w_load_stable = w_eval && w_same && (r_dc == DC_PRE);
  assign w_push        = w_load_stable && (r_stable == '0) && $onehot(r_cand);

  // Snapshot bit 4*col+row maps to code {row, col}.
  always_comb begin
    w_idx  = '0;
    w_code = '0;
    for (int i = 0; i < 16; i++) begin
      if (r_cand[i]) w_idx = 4'(i);
    end
    w_code = {w_idx[1:0], w_idx[3:2]};
  end

  assign w_pop  = r_key_valid && kp.KEY_READY;
  assign w_full = (r_count == 3'd4);
  assign w_wr   = w_push && (!w_full || w_pop);
  assign w_drop = w_push && w_full && !w_pop;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr, w_pop})
      2'b10:   w_count_nxt = r_count + 3'd1;
      2'b01:   w_count_nxt = r_count - 3'd1;
      default: w_count_nxt = r_count;
    endcase
    w_rd_nxt = w_pop ? r_rd_ptr + 2'd1 : r_rd_ptr;
    // Bypass the write when the entry landing at the head is written this cycle.
    if (w_count_nxt == 3'd0)
      w_head_nxt = '0;
    else if (w_wr && (r_wr_ptr == w_rd_nxt))
      w_head_nxt = w_code;
    else
      w_head_nxt = r_mem[w_rd_nxt];
  end

  always_ff @(posedge CLK or negedge ARSTL) begin
    if (!ARSTL) begin
      r_snap      <= '0;
      r_cand      <= '0;
      r_stable    <= '0;
      r_dc        <= '0;
      for (int i = 0; i < 4; i++) r_mem[i] <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_key_valid <= 1'b0;
      r_key_code  <= '0;
      r_ovf       <= 1'b0;
    end else begin
      if (w_capture) r_snap[{r_c, 2'b00} +: 4] <= ~kp.ROW;
      if (w_eval) begin
        if (!w_same) begin
          r_cand <= r_snap;
          r_dc   <= '0;
        end else if (r_dc != DC_LAST) begin
          r_dc <= r_dc + 4'd1;
        end
      end
      if (w_load_stable) r_stable <= r_cand;
      if (w_wr) begin
        r_mem[r_wr_ptr] <= w_code;
        r_wr_ptr        <= r_wr_ptr + 2'd1;
      end
      r_rd_ptr    <= w_rd_nxt;
      r_count     <= w_count_nxt;
      r_key_valid <= (w_count_nxt != 3'd0);
      r_key_code  <= w_head_nxt;
      if (w_drop)
        r_ovf <= 1'b1;
      else if (kp.CLR_OVF)
        r_ovf <= 1'b0;
    end
  end

  assign kp.COL       = r_col;
  assign kp.KEY_VALID = r_key_valid;
  assign kp.KEY_CODE  = r_key_code;
  assign kp.KEY_HELD  = $onehot(r_stable);
  assign kp.OVERFLOW  = r_ovf;

endmodule

// File: tb/tb_kypd_scan_ctrl.sv
// Directed bench for kypd_scan_ctrl (SETTLE_CYC=4, DEBOUNCE_CNT=3, 17-cycle sweep)
// driving a 4x4 key-matrix model; vectors are applied at sweep boundaries.
module tb_kypd_scan_ctrl;
  logic        CLK;
  logic        ARSTL;
  logic [15:0] keys;
  int          cyc;
  int          checks;
  int          errors;

  typedef struct {
    logic [15:0] keys;
    int          sweeps;
    logic        held;
    logic        valid;
    logic [3:0]  code;
    logic        ovf;
  } vec_t;

  vec_t tbl[22];

  kypd_scan_ctrl_if u_if();

  kypd_scan_ctrl #(.SETTLE_CYC(4), .DEBOUNCE_CNT(3)) dut (
    .CLK   (CLK),
    .ARSTL (ARSTL),
    .kp    (u_if)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Key (r,c) is mask bit 4*c+r; it pulls row r low while column c is strobed.
  always_comb begin
    u_if.ROW = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (keys[4*c+r] && !u_if.COL[c]) u_if.ROW[r] = 1'b0;
  end

  always @(posedge CLK or negedge ARSTL) begin
    if (!ARSTL) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic sweeps(input int n);
    repeat (17*n) @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic align();
    while (cyc % 17 != 0) @(negedge CLK);
  endtask

  task automatic pop_chk(input logic [3:0] exp);
    chk("pop_valid", u_if.KEY_VALID, 1'b1);
    chk("pop_code", u_if.KEY_CODE, exp);
    u_if.KEY_READY = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    u_if.KEY_READY = 1'b0;
  endtask

  // Press k from a sweep boundary and apply ready/clr only on the push edge (3rd EVAL).
  task automatic push_at_edge(input logic [15:0] k, input logic rdy, input logic clr);
    keys = k;
    repeat (50) @(posedge CLK);
    @(negedge CLK);
    chk("pre_push_cyc16", u_if.COL, 4'b1110);
    u_if.KEY_READY = rdy;
    u_if.CLR_OVF   = clr;
    @(posedge CLK);
    @(negedge CLK);
    u_if.KEY_READY = 1'b0;
    u_if.CLR_OVF   = 1'b0;
  endtask

  task automatic run_tbl(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      keys = tbl[i].keys;
      sweeps(tbl[i].sweeps);
      chk($sformatf("vec%0d_held", i), u_if.KEY_HELD, tbl[i].held);
      chk($sformatf("vec%0d_valid", i), u_if.KEY_VALID, tbl[i].valid);
      if (tbl[i].valid) chk($sformatf("vec%0d_code", i), u_if.KEY_CODE, tbl[i].code);
      chk($sformatf("vec%0d_ovf", i), u_if.OVERFLOW, tbl[i].ovf);
    end
  endtask

  initial begin
    repeat (20000) @(posedge CLK);
    $display("FAIL watchdog actual=%0d cycles expected=<20000", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ec;
    int p;
    checks = 0;
    errors = 0;
    tbl[0]  = '{16'h0200, 2, 1'b1, 1'b1, 4'b0110, 1'b0};
    tbl[1]  = '{16'h0000, 2, 1'b1, 1'b1, 4'b0110, 1'b0};
    tbl[2]  = '{16'h0000, 1, 1'b0, 1'b1, 4'b0110, 1'b0};
    tbl[3]  = '{16'h0050, 3, 1'b0, 1'b0, 4'b0000, 1'b0};
    tbl[4]  = '{16'h0000, 3, 1'b0, 1'b0, 4'b0000, 1'b0};
    tbl[5]  = '{16'h0008, 1, 1'b0, 1'b0, 4'b0000, 1'b0};
    tbl[6]  = '{16'h0000, 1, 1'b0, 1'b0, 4'b0000, 1'b0};
    tbl[7]  = '{16'h0008, 1, 1'b0, 1'b0, 4'b0000, 1'b0};
    tbl[8]  = '{16'h0000, 1, 1'b0, 1'b0, 4'b0000, 1'b0};
    tbl[9]  = '{16'h0008, 2, 1'b0, 1'b0, 4'b0000, 1'b0};
    tbl[10] = '{16'h0008, 1, 1'b1, 1'b1, 4'b1100, 1'b0};
    tbl[11] = '{16'h1008, 3, 1'b0, 1'b1, 4'b1100, 1'b0};
    tbl[12] = '{16'h0008, 3, 1'b1, 1'b1, 4'b1100, 1'b0};
    tbl[13] = '{16'h0000, 3, 1'b0, 1'b1, 4'b1100, 1'b0};
    tbl[14] = '{16'h0001, 3, 1'b1, 1'b1, 4'b0000, 1'b0};
    tbl[15] = '{16'h0000, 3, 1'b0, 1'b1, 4'b0000, 1'b0};
    tbl[16] = '{16'h0020, 3, 1'b1, 1'b1, 4'b0000, 1'b0};
    tbl[17] = '{16'h0000, 3, 1'b0, 1'b1, 4'b0000, 1'b0};
    tbl[18] = '{16'h4000, 3, 1'b1, 1'b1, 4'b0000, 1'b0};
    tbl[19] = '{16'h0000, 3, 1'b0, 1'b1, 4'b0000, 1'b0};
    tbl[20] = '{16'h0800, 3, 1'b1, 1'b1, 4'b0000, 1'b0};
    tbl[21] = '{16'h0000, 3, 1'b0, 1'b1, 4'b0000, 1'b0};

    keys           = '0;
    u_if.KEY_READY = 1'b0;
    u_if.CLR_OVF   = 1'b0;
    ARSTL          = 1'b1;
    #2 ARSTL = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_col", u_if.COL, 4'b1110);
    chk("rst_valid", u_if.KEY_VALID, 1'b0);
    chk("rst_code", u_if.KEY_CODE, 4'b0000);
    chk("rst_held", u_if.KEY_HELD, 1'b0);
    chk("rst_ovf", u_if.OVERFLOW, 1'b0);
    ARSTL = 1'b1;

    // Idle sweeps: 4 cycles per column then one EVAL cycle at column 0.
    for (int i = 0; i < 34; i++) begin
      p  = i % 17;
      ec = 4'b1110;
      if (p < 16) ec = ~(4'b0001 << (p / 4));
      chk($sformatf("idle_col%0d", i), u_if.COL, ec);
      chk($sformatf("idle_valid%0d", i), u_if.KEY_VALID, 1'b0);
      @(negedge CLK);
    end

    // Row 1 / column 2 key: event exactly at the 3rd EVAL, visible next cycle.
    keys = 16'h0200;
    sweeps(2);
    repeat (16) @(posedge CLK);
    @(negedge CLK);
    chk("press_eval_col", u_if.COL, 4'b1110);
    chk("press_eval_valid", u_if.KEY_VALID, 1'b0);
    chk("press_eval_held", u_if.KEY_HELD, 1'b0);
    @(negedge CLK);
    chk("press_valid", u_if.KEY_VALID, 1'b1);
    chk("press_code", u_if.KEY_CODE, 4'b0110);
    chk("press_held", u_if.KEY_HELD, 1'b1);

    run_tbl(0, 2);
    pop_chk(4'b0110);
    chk("pop1_empty", u_if.KEY_VALID, 1'b0);
    align();

    // Ghost pair, bounce, then one->multi->one without passing through zero.
    run_tbl(3, 13);
    pop_chk(4'b1100);
    chk("multi_no_extra", u_if.KEY_VALID, 1'b0);
    align();

    // Fill the FIFO with four events, then drop a fifth with clear on the same edge.
    run_tbl(14, 21);
    push_at_edge(16'h0004, 1'b0, 1'b1);
    chk("drop_ovf_set_wins", u_if.OVERFLOW, 1'b1);
    chk("drop_head", u_if.KEY_CODE, 4'b0000);
    keys = '0;
    sweeps(3);
    chk("ovf_sticky", u_if.OVERFLOW, 1'b1);
    u_if.CLR_OVF = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    u_if.CLR_OVF = 1'b0;
    chk("ovf_cleared", u_if.OVERFLOW, 1'b0);
    align();

    // Push while full with a simultaneous pop: count unchanged, no overflow.
    push_at_edge(16'h1000, 1'b1, 1'b0);
    chk("full_pushpop_ovf", u_if.OVERFLOW, 1'b0);
    chk("full_pushpop_valid", u_if.KEY_VALID, 1'b1);
    keys = '0;
    sweeps(3);
    pop_chk(4'b0101);
    pop_chk(4'b1011);
    pop_chk(4'b1110);
    pop_chk(4'b0011);
    chk("drain_empty", u_if.KEY_VALID, 1'b0);
    align();

    // Push and pop together with a single entry queued.
    keys = 16'h0001;
    sweeps(3);
    chk("one_valid", u_if.KEY_VALID, 1'b1);
    chk("one_code", u_if.KEY_CODE, 4'b0000);
    keys = '0;
    sweeps(3);
    push_at_edge(16'h0020, 1'b1, 1'b0);
    chk("one_pushpop_valid", u_if.KEY_VALID, 1'b1);
    chk("one_pushpop_code", u_if.KEY_CODE, 4'b0101);
    pop_chk(4'b0101);
    chk("one_pushpop_empty", u_if.KEY_VALID, 1'b0);
    align();

    // Reset mid-debounce with two events queued and a key still held.
    keys = '0;
    sweeps(3);
    keys = 16'h0001;
    sweeps(3);
    keys = '0;
    sweeps(3);
    keys = 16'h4000;
    sweeps(3);
    keys = '0;
    sweeps(3);
    chk("pre_rst_valid", u_if.KEY_VALID, 1'b1);
    chk("pre_rst_code", u_if.KEY_CODE, 4'b0000);
    keys = 16'h0800;
    sweeps(1);
    repeat (5) @(posedge CLK);
    #3 ARSTL = 1'b0;
    #1;
    chk("async_rst_valid", u_if.KEY_VALID, 1'b0);
    chk("async_rst_col", u_if.COL, 4'b1110);
    chk("async_rst_held", u_if.KEY_HELD, 1'b0);
    repeat (3) @(negedge CLK);
    ARSTL = 1'b1;
    sweeps(2);
    chk("post_rst_valid2", u_if.KEY_VALID, 1'b0);
    chk("post_rst_held2", u_if.KEY_HELD, 1'b0);
    sweeps(1);
    chk("post_rst_valid3", u_if.KEY_VALID, 1'b1);
    chk("post_rst_code3", u_if.KEY_CODE, 4'b1110);
    chk("post_rst_held3", u_if.KEY_HELD, 1'b1);
    pop_chk(4'b1110);
    chk("post_rst_flushed", u_if.KEY_VALID, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
